// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared sizes and types for the FP32 register file and its scoreboard
package fp_rf_pkg;
    localparam int NUM_FP_REGS = 32;
    localparam int FP_ADDR_W = $clog2(NUM_FP_REGS);
    typedef logic [FP_ADDR_W-1:0] fp_reg_addr_t;
    typedef logic [31:0] fp_word_t;
endpackage

// File: rtl/fp_sb_hazard.sv
// fp_sb_hazard: pending-write bits per FP register and the RAW/WAW issue stall
module fp_sb_hazard
    import fp_rf_pkg::*;
#(
    parameter int NUM_REGS = NUM_FP_REGS,
    parameter int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic [ADDR_W-1:0]   rs3_addr,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_uses_rs3,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic                issue_stall,
    output logic [NUM_REGS-1:0] busy_mask
);
    logic [NUM_REGS-1:0] clr, set, hz;
    // A writeback landing this cycle already releases its register
    assign clr = wb_en ? NUM_REGS'(1) << wb_addr : '0;
    assign hz = busy_mask & ~clr;
    assign issue_stall = issue_valid &&
        (hz[rs1_addr] || hz[rs2_addr] || (issue_uses_rs3 && hz[rs3_addr]) || hz[issue_rd]);
    assign set = (issue_valid && !issue_stall) ? NUM_REGS'(1) << issue_rd : '0;
    // Set applied after clear so a new producer keeps ownership
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy_mask <= '0;
        else busy_mask <= (busy_mask & ~clr) | set;
endmodule

// File: rtl/register_32bit.sv
// register_32bit: 32-bit load-enable register with asynchronous active-low clear
module register_32bit
    import fp_rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  fp_word_t d,
    output fp_word_t q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/fp_regfile_scoreboard.sv
// fp_regfile_scoreboard: 32x32 FP register file, 3 bypassed read ports, 1 writeback,
// and a pending-write scoreboard that stalls issue on RAW/WAW hazards
module fp_regfile_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = NUM_FP_REGS,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic [ADDR_W-1:0]   rs3_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    output logic [DATA_W-1:0]   rs3_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_uses_rs3,
    output logic                issue_stall,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_mask
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        register_32bit u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wb_en && wb_addr == ADDR_W'(i)),
            .d     (wb_data),
            .q     (regs[i])
        );
    end
    // Same-cycle writeback forwards straight to the readers
    assign rs1_data = (wb_en && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
    assign rs2_data = (wb_en && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
    assign rs3_data = (wb_en && wb_addr == rs3_addr) ? wb_data : regs[rs3_addr];
    fp_sb_hazard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs3_addr       (rs3_addr),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_uses_rs3 (issue_uses_rs3),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .issue_stall    (issue_stall),
        .busy_mask      (busy_mask)
    );
endmodule

// File: tb/tb_fp_regfile_scoreboard.sv
// tb_fp_regfile_scoreboard: directed and random stimulus against a behavioural
// register-file/scoreboard model, checked by a queue-driven monitor
module tb_fp_regfile_scoreboard;
    logic        clk = 0;
    logic        rst_n = 1;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, rs3_addr = 0, issue_rd = 0, wb_addr = 0;
    logic [31:0] rs1_data, rs2_data, rs3_data, wb_data = 0, busy_mask;
    logic        issue_valid = 0, issue_uses_rs3 = 0, issue_stall, wb_en = 0;

    fp_regfile_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs3_addr       (rs3_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rs3_data       (rs3_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_uses_rs3 (issue_uses_rs3),
        .issue_stall    (issue_stall),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .busy_mask      (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d1, d2, d3, bm;
        logic        st;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    int          compared = 0, mismatched = 0;

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        return (wb_en && wb_addr == a) ? wb_data : m_reg[a];
    endfunction

    function automatic bit hz_model(input logic [4:0] a);
        return m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic exp_t predict(input string tag);
        exp_t e;
        e.tag = tag;
        e.d1 = rd_model(rs1_addr);
        e.d2 = rd_model(rs2_addr);
        e.d3 = rd_model(rs3_addr);
        e.st = issue_valid && (hz_model(rs1_addr) || hz_model(rs2_addr) ||
               (issue_uses_rs3 && hz_model(rs3_addr)) || hz_model(issue_rd));
        for (int i = 0; i < 32; i++) e.bm[i] = m_busy[i];
        return e;
    endfunction

    // One cycle: apply inputs, queue the expected response, then commit the model at the edge
    task automatic cyc(input string tag, input bit v, input int rd, input bit u3,
                       input int r1, input int r2, input int r3,
                       input bit we, input int wa, input logic [31:0] wd);
        exp_t e;
        issue_valid = v; issue_rd = 5'(rd); issue_uses_rs3 = u3;
        rs1_addr = 5'(r1); rs2_addr = 5'(r2); rs3_addr = 5'(r3);
        wb_en = we; wb_addr = 5'(wa); wb_data = wd;
        if (!rst_n)
            for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
        e = predict(tag);
        q.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (we) begin m_reg[wa] = wd; m_busy[wa] = 0; end
            if (v && !e.st) m_busy[rd] = 1;
        end
        #1;
    endtask

    task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", tag, f, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.tag, "rs1_data", rs1_data, e.d1);
                chk(e.tag, "rs2_data", rs2_data, e.d2);
                chk(e.tag, "rs3_data", rs3_data, e.d3);
                chk(e.tag, "issue_stall", 32'(issue_stall), 32'(e.st));
                chk(e.tag, "busy_mask", busy_mask, e.bm);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
        @(posedge clk); #1;
        rst_n = 0;
        cyc("reset", 1, 5, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        cyc("bypass", 0, 0, 0, 0, 3, 0, 1, 3, 32'h3F80_0000);
        cyc("array_read", 0, 0, 0, 3, 0, 0, 0, 0, 0);
        cyc("raw_issue", 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw_stall", 1, 8, 0, 7, 0, 0, 0, 0, 0);
        cyc("raw_wb_mask", 1, 8, 0, 7, 0, 0, 1, 7, 32'h1111_2222);
        cyc("raw_cleared", 0, 0, 0, 7, 0, 0, 0, 0, 0);
        cyc("waw_set9", 1, 9, 0, 0, 0, 0, 0, 0, 0);
        cyc("waw_set12", 1, 12, 0, 0, 0, 0, 0, 0, 0);
        cyc("waw_stall", 1, 9, 0, 0, 0, 0, 0, 0, 0);
        cyc("rs3_ignored", 1, 13, 0, 0, 0, 12, 0, 0, 0);
        cyc("rs3_used", 1, 14, 1, 0, 0, 12, 0, 0, 0);
        cyc("simul_set4", 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("simul_wb_issue", 1, 4, 0, 0, 0, 0, 1, 4, 32'h4000_0000);
        cyc("simul_after", 0, 0, 0, 4, 0, 0, 0, 0, 0);
        cyc("busy_f1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("busy_f2", 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc("busy_f31", 1, 31, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        cyc("mid_reset", 0, 0, 0, 3, 4, 7, 0, 0, 0);
        rst_n = 1;
        cyc("late_wb", 0, 0, 0, 2, 0, 0, 1, 2, 32'h1234_5678);
        cyc("late_wb_after", 0, 0, 0, 2, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
            rst_n = ($urandom_range(0, 99) != 0);
            cyc("random", $urandom_range(0, 1), $urandom_range(0, lim), $urandom_range(0, 1),
                $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                $urandom_range(0, 2) != 0, $urandom_range(0, lim), $urandom);
        end
        rst_n = 1;
        issue_valid = 0; wb_en = 0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
